// File: rtl/mmio_display_pkg.sv
// mmio_display shared constants: register offsets and 7-seg codes.
// Optional build macro used by the top: MMIO_DISP_BLANK_EN.
package mmio_display_pkg;

    localparam logic [3:0] OFS_DIG0 = 4'd0;
    localparam logic [3:0] OFS_DIG1 = 4'd1;
    localparam logic [3:0] OFS_DIG2 = 4'd2;
    localparam logic [3:0] OFS_DIG3 = 4'd3;
    localparam logic [3:0] OFS_CHR0 = 4'd4;
    localparam logic [3:0] OFS_CHR1 = 4'd5;
    localparam logic [3:0] OFS_CHR2 = 4'd6;
    localparam logic [3:0] OFS_CHR3 = 4'd7;
    localparam logic [3:0] OFS_BTN  = 4'd8;

    localparam logic [3:0] MASK_IDLE = 4'b1110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/mmio_display_seg7_enc.sv
// seg7_enc: hex nibble to active-low 7-segment code.
// Purely combinational.
module seg7_enc
    import mmio_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/mmio_display.sv
// mmio_display: bus-mapped hex digits, char LEDs and button flags,
// scanned onto 7-seg and LED banks. MMIO_DISP_BLANK_EN: zero blanking.
module mmio_display
    import mmio_display_pkg::*;
#(
    parameter int         SCAN_DIV_W = 16,
    parameter int         SCAN_DIV   = 50000,
    parameter logic [7:0] BASE       = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] di,
    input  logic [3:0] btn_pulse,
    output logic       hit,
    output logic [7:0] rdata,
    output logic [6:0] num,
    output logic [3:0] n_mask,
    output logic [7:0] char,
    output logic [3:0] c_mask
);

    logic [3:0]            dig [4];
    logic [7:0]            chr [4];
    logic [3:0]            flags;
    logic [SCAN_DIV_W-1:0] pre;
    logic [1:0]            idx;
    logic [7:0]            off;
    logic                  wr_en;
    logic [3:0]            w1c;
    logic [6:0]            seg;
    logic                  blank;

    assign off   = addr - BASE;
    assign hit   = (off <= 8'd8);
    assign wr_en = we && hit;
    assign w1c   = (wr_en && off[3:0] == OFS_BTN) ? di[3:0] : 4'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                dig[i] <= '0;
                chr[i] <= '0;
            end
        end else if (wr_en) begin
            case (off[3:0])
                OFS_DIG0: dig[0] <= di[3:0];
                OFS_DIG1: dig[1] <= di[3:0];
                OFS_DIG2: dig[2] <= di[3:0];
                OFS_DIG3: dig[3] <= di[3:0];
                OFS_CHR0: chr[0] <= di;
                OFS_CHR1: chr[1] <= di;
                OFS_CHR2: chr[2] <= di;
                OFS_CHR3: chr[3] <= di;
                default: ;
            endcase
        end
    end

    // Set is applied after the W1C clear so a same-cycle pulse survives
    always_ff @(posedge clk) begin
        if (rst) flags <= '0;
        else     flags <= (flags & ~w1c) | btn_pulse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == SCAN_DIV_W'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off[3:0])
                OFS_DIG0: rdata = {4'b0, dig[0]};
                OFS_DIG1: rdata = {4'b0, dig[1]};
                OFS_DIG2: rdata = {4'b0, dig[2]};
                OFS_DIG3: rdata = {4'b0, dig[3]};
                OFS_CHR0: rdata = chr[0];
                OFS_CHR1: rdata = chr[1];
                OFS_CHR2: rdata = chr[2];
                OFS_CHR3: rdata = chr[3];
                OFS_BTN:  rdata = {4'b0, flags};
                default:  rdata = '0;
            endcase
        end
    end

    seg7_enc u_seg7 (
        .hex (dig[idx]),
        .seg (seg)
    );

`ifdef MMIO_DISP_BLANK_EN
    // Digit 3 is most significant; digit 0 always shows
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd1: blank = (dig[1] == 0) && (dig[2] == 0) && (dig[3] == 0);
            2'd2: blank = (dig[2] == 0) && (dig[3] == 0);
            2'd3: blank = (dig[3] == 0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            n_mask <= MASK_IDLE;
            c_mask <= MASK_IDLE;
            num    <= SEG_0;
            char   <= 8'hFF;
        end else begin
            n_mask <= ~(4'b0001 << idx);
            c_mask <= ~(4'b0001 << idx);
            num    <= blank ? SEG_BLANK : seg;
            char   <= ~chr[idx];
        end
    end

endmodule

// File: tb/tb_mmio_display.sv
// Randomized bench for mmio_display against a cycle-count model.
// Build with MMIO_DISP_BLANK_EN to exercise zero blanking.
module tb_mmio_display;

    localparam int         SCAN_DIV = 4;
    localparam logic [7:0] BASE     = 8'hF0;

    logic       clk;
    logic       rst;
    logic       we;
    logic [7:0] addr;
    logic [7:0] di;
    logic [3:0] btn_pulse;
    logic       hit;
    logic [7:0] rdata;
    logic [6:0] num;
    logic [3:0] n_mask;
    logic [7:0] char;
    logic [3:0] c_mask;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] m_dig [4];
    logic [7:0] m_chr [4];
    logic [3:0] m_flg;
    int         m_t;
    bit         m_known;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    mmio_display #(
        .SCAN_DIV_W (16),
        .SCAN_DIV   (SCAN_DIV),
        .BASE       (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .addr      (addr),
        .di        (di),
        .btn_pulse (btn_pulse),
        .hit       (hit),
        .rdata     (rdata),
        .num       (num),
        .n_mask    (n_mask),
        .char      (char),
        .c_mask    (c_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] m_read(input logic [7:0] a);
        int off;
        off = int'(a) - int'(BASE);
        if (off < 0 || off > 8) return 9'h0;
        if (off < 4) return {1'b1, 4'b0, m_dig[off]};
        if (off < 8) return {1'b1, m_chr[off-4]};
        return {1'b1, 4'b0, m_flg};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = '0;
            m_chr[i] = '0;
        end
        m_flg = '0;
        m_t   = 0;
    endtask

    // One clock: check bus reads, predict and check scan outputs
    task automatic tick();
        int          idx;
        int          off;
        logic [8:0]  r;
        logic [15:0] word;
        logic [3:0]  em;
        logic [6:0]  en;
        logic [7:0]  ec;
        bit          chk;
        #2;
        r = m_read(addr);
        check("hit", 32'(hit), 32'(r[8]));
        check("rdata", 32'(rdata), 32'(r[7:0]));
        idx  = (m_t / SCAN_DIV) % 4;
        word = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        em   = ~(4'b0001 << idx);
        en   = seg_tab[m_dig[idx]];
`ifdef MMIO_DISP_BLANK_EN
        if (idx != 0 && (word >> (4 * idx)) == 0) en = 7'h7F;
`endif
        ec   = ~m_chr[idx];
        chk  = m_known;
        if (rst) begin
            em = 4'b1110;
            en = 7'h40;
            ec = 8'hFF;
            m_clear();
            m_known = 1'b1;
            chk = 1'b1;
        end else begin
            off = int'(addr) - int'(BASE);
            if (we && off >= 0 && off <= 8) begin
                if (off < 4)      m_dig[off] = di[3:0];
                else if (off < 8) m_chr[off-4] = di;
                else              m_flg = m_flg & ~di[3:0];
            end
            m_flg = m_flg | btn_pulse;
            m_t++;
        end
        @(posedge clk);
        #1;
        if (chk) begin
            check("n_mask", 32'(n_mask), 32'(em));
            check("c_mask", 32'(c_mask), 32'(em));
            check("num", 32'(num), 32'(en));
            check("char", 32'(char), 32'(ec));
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        we   = 1'b1;
        addr = a;
        di   = d;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        addr = a;
        tick();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int guard;
        m_clear();
        m_known   = 1'b0;
        rst       = 1'b1;
        we        = 1'b0;
        addr      = 8'h00;
        di        = 8'h00;
        btn_pulse = 4'b0;
        @(negedge clk);

        run(2);
        rst = 1'b0;
        run(20);

        wr(8'hF0, 8'h03);
        wr(8'hF1, 8'h0A);
        wr(8'hF2, 8'h00);
        wr(8'hF3, 8'hF7);
        run(16);

        wr(8'hF5, 8'h81);
        run(16);
        rd(8'hF5);
        rd(8'hE0);
        rd(8'hF9);

        btn_pulse = 4'b0101;
        rd(8'hF8);
        btn_pulse = 4'b0000;
        rd(8'hF8);
        wr(8'hF8, 8'h01);
        rd(8'hF8);
        btn_pulse = 4'b0100;
        wr(8'hF8, 8'h04);
        btn_pulse = 4'b0000;
        rd(8'hF8);

        guard = 0;
        while ((m_t % 16) != 9 && guard < 32) begin
            tick();
            guard++;
        end
        check("mid_slot_reach", 32'(m_t % 16), 32'd9);
        we   = 1'b1;
        addr = 8'hF0;
        di   = 8'h0F;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        we   = 1'b0;
        for (int a = 'hF0; a <= 'hF8; a++) rd(8'(a));
        run(8);

        wr(8'hF0, 8'h00);
        wr(8'hF1, 8'h05);
        wr(8'hF2, 8'h00);
        wr(8'hF3, 8'h00);
        run(20);
        wr(8'hF2, 8'h01);
        run(16);

        for (int i = 0; i < 1500; i++) begin
            we        = ($urandom_range(0, 1) == 1);
            addr      = 8'($urandom_range(232, 255));
            di        = 8'($urandom);
            btn_pulse = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst       = 1'b0;
        we        = 1'b0;
        btn_pulse = 4'b0;
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
